// File: rtl/imem_sram_slave_if.sv
// Fetch request/response handshake plus preload port between the fetch side and the instruction SRAM.
interface imem_sram_slave_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic        rdata_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  modport master (
    output req_valid, req_addr, rdata_ready, load_en, load_addr, load_data,
    input  req_ready, rdata, rdata_valid, rdata_err
  );

  modport slave (
    input  req_valid, req_addr, rdata_ready, load_en, load_addr, load_data,
    output req_ready, rdata, rdata_valid, rdata_err
  );
endinterface

// File: rtl/imem_sram_slave.sv
// Instruction SRAM slave: one outstanding fetch, LATENCY (+0..3 LFSR) cycles to response.
// Response held until rdata_ready; no new request is accepted while a fetch is outstanding.
module imem_sram_slave #(
  parameter int          AW         = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 1,
  parameter bit          RAND_DELAY = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  imem_sram_slave_if.slave bus
);

  // 33-bit compare so a window ending at 4 GiB cannot wrap.
  localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + (33'd1 << (AW + 2)) - 33'd1;
  localparam logic [4:0]  LAT       = 5'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [4:0]     cnt;
  logic [7:0]     lfsr;
  logic [AW-1:0]  idx_q;
  logic           inr_q;
  logic [31:0]    rdata_q;
  logic           valid_q;
  logic           err_q;
  logic [31:0]    mem [2**AW];

  logic           req_inr;
  logic [AW-1:0]  req_idx;
  logic           load_inr;
  logic [AW-1:0]  load_idx;
  logic [4:0]     dly;
  logic [7:0]     lfsr_nxt;

  always_comb begin
    req_inr  = ({1'b0, bus.req_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, bus.req_addr} <= LAST_ADDR);
    req_idx  = AW'((bus.req_addr - BASE_ADDR) >> 2);
    load_inr = ({1'b0, bus.load_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, bus.load_addr} <= LAST_ADDR);
    load_idx = AW'((bus.load_addr - BASE_ADDR) >> 2);
    dly      = LAT + (RAND_DELAY ? {3'b000, lfsr[1:0]} : 5'd0);
    lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign bus.req_ready   = (state == IDLE) && !rst;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = valid_q;
  assign bus.rdata_err   = err_q;

  // Preload writes land after any same-edge read, so that read sees the old word.
  always_ff @(posedge clk) begin
    if (bus.load_en && load_inr) mem[load_idx] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      lfsr    <= 8'hA5;
      idx_q   <= '0;
      inr_q   <= 1'b0;
      rdata_q <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lfsr  <= lfsr_nxt;
            idx_q <= req_idx;
            inr_q <= req_inr;
            cnt   <= dly - 5'd1;
            if (dly == 5'd1) begin
              state   <= RESP;
              valid_q <= 1'b1;
              rdata_q <= req_inr ? mem[req_idx] : 32'h0;
              err_q   <= !req_inr;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state   <= RESP;
            valid_q <= 1'b1;
            rdata_q <= inr_q ? mem[idx_q] : 32'h0;
            err_q   <= !inr_q;
          end
        end
        RESP: begin
          if (bus.rdata_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_sram_slave.sv
// Two slaves (random-delay and fixed LATENCY=3) driven by shared stimulus, each checked against a transaction-level model.
module tb_imem_sram_slave;
  localparam int          AW    = 4;
  localparam int          WORDS = 1 << AW;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        rdata_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = 32'h0;
  logic [31:0] load_data = 32'h0;

  always #5 clk = ~clk;

  imem_sram_slave_if ifa ();
  imem_sram_slave_if ifb ();

  assign ifa.req_valid = req_valid;   assign ifb.req_valid = req_valid;
  assign ifa.req_addr = req_addr;     assign ifb.req_addr = req_addr;
  assign ifa.rdata_ready = rdata_ready; assign ifb.rdata_ready = rdata_ready;
  assign ifa.load_en = load_en;       assign ifb.load_en = load_en;
  assign ifa.load_addr = load_addr;   assign ifb.load_addr = load_addr;
  assign ifa.load_data = load_data;   assign ifb.load_data = load_data;

  imem_sram_slave #(.AW(AW), .BASE_ADDR(BASE), .LATENCY(1), .RAND_DELAY(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  imem_sram_slave #(.AW(AW), .BASE_ADDR(BASE), .LATENCY(3), .RAND_DELAY(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [1:0]  o_rdy, o_vld, o_err;
  logic [31:0] o_dat [2];
  assign o_rdy = {ifb.req_ready, ifa.req_ready};
  assign o_vld = {ifb.rdata_valid, ifa.rdata_valid};
  assign o_err = {ifb.rdata_err, ifa.rdata_err};
  assign o_dat[0] = ifa.rdata;
  assign o_dat[1] = ifb.rdata;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  int          lat_k [2] = '{1, 3};
  bit          rnd_k [2] = '{1'b1, 1'b0};
  logic [31:0] mmem [WORDS];
  bit          m_busy [2], m_resp [2], m_inr [2], m_err [2];
  int          m_due [2], m_idx [2];
  logic [31:0] m_dat [2];
  logic [7:0]  m_lfsr [2];
  bit          m_live = 1'b0;
  int          ecnt = 0;

  function automatic bit inrange(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * WORDS);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 4) % WORDS;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic capture(input int k);
    m_busy[k] = 1'b0;
    m_resp[k] = 1'b1;
    m_dat[k]  = m_inr[k] ? mmem[m_idx[k]] : 32'h0;
    m_err[k]  = !m_inr[k];
  endtask

  always @(posedge clk) begin
    int d;
    ecnt++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0; m_resp[k] = 1'b0; m_dat[k] = 32'h0; m_err[k] = 1'b0; m_lfsr[k] = 8'hA5;
      end else if (m_resp[k]) begin
        if (rdata_ready) m_resp[k] = 1'b0;
      end else if (m_busy[k]) begin
        if (ecnt == m_due[k]) capture(k);
      end else if (req_valid) begin
        d = lat_k[k] + (rnd_k[k] ? int'(m_lfsr[k] % 4) : 0);
        m_lfsr[k] = lfsr_step(m_lfsr[k]);
        m_inr[k]  = inrange(req_addr);
        m_idx[k]  = widx(req_addr);
        m_due[k]  = ecnt + d - 1;
        m_busy[k] = 1'b1;
        if (d == 1) capture(k);
      end
    end
    if (load_en && inrange(load_addr)) mmem[widx(load_addr)] = load_data;
    if (rst) m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req_ready[%0d]", k), 32'(o_rdy[k]), 32'(!rst && !m_busy[k] && !m_resp[k]));
        chk($sformatf("rdata_valid[%0d]", k), 32'(o_vld[k]), 32'(m_resp[k]));
        if (m_resp[k]) begin
          chk($sformatf("rdata[%0d]", k), o_dat[k], m_dat[k]);
          chk($sformatf("rdata_err[%0d]", k), 32'(o_err[k]), 32'(m_err[k]));
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  int          r_lat [2];
  logic [31:0] r_dat [2];
  logic        r_err [2];
  int          seqs [2][16];

  task automatic wait_idle();
    int t = 0;
    while (o_rdy !== 2'b11 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 40) timeout("wait_idle");
  endtask

  // One request; latency n counts edges from acceptance, so n equals the delay D.
  task automatic do_req(input logic [31:0] a, input bit hold, input int ld_rel, input logic [31:0] ld_val);
    int n;
    wait_idle();
    req_addr = a; req_valid = 1'b1; rdata_ready = !hold;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat[0] = -1; r_lat[1] = -1;
    n = 1;
    while (n <= 40) begin
      for (int k = 0; k < 2; k++)
        if (o_vld[k] && r_lat[k] < 0) begin
          r_lat[k] = n; r_dat[k] = o_dat[k]; r_err[k] = o_err[k];
        end
      if (r_lat[0] >= 0 && r_lat[1] >= 0) break;
      load_en = (n == ld_rel); load_addr = a; load_data = ld_val;
      @(posedge clk); #1;
      n++;
    end
    load_en = 1'b0;
    for (int k = 0; k < 2; k++) if (r_lat[k] < 0) timeout($sformatf("response[%0d]", k));
  endtask

  task automatic expect_req(input string name, input int la, input int lb, input logic [31:0] dat, input bit err);
    chk({name, " lat_a"}, 32'(r_lat[0]), 32'(la));
    chk({name, " lat_b"}, 32'(r_lat[1]), 32'(lb));
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s dat[%0d]", name, k), r_dat[k], dat);
      chk($sformatf("%s err[%0d]", name, k), 32'(r_err[k]), 32'(err));
    end
  endtask

  task automatic collect(input int which);
    int n, acc, got;
    logic prv_rdy, prv_vld;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    rdata_ready = 1'b1; req_valid = 1'b1;
    n = 0; acc = 0; got = 0;
    prv_rdy = o_rdy[0]; prv_vld = o_vld[0];
    while (got < 16 && n < 200) begin
      req_addr = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
      @(posedge clk); #1;
      n++;
      if (prv_rdy) acc = n;
      if (o_vld[0] && !prv_vld) begin
        seqs[which][got] = n - acc + 1;
        got++;
      end
      prv_rdy = o_rdy[0]; prv_vld = o_vld[0];
    end
    req_valid = 1'b0;
    if (got < 16) timeout("delay_sequence");
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 32'd4 + 32'($urandom_range(0, 3));
      1:       return BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 7));
      2:       return $urandom;
      default: return BASE + 32'($urandom_range(0, 4 * WORDS - 1));
    endcase
  endfunction

  // ---------------- directed and random stimulus ----------------
  initial begin
    int seen;
    int exp5 [5] = '{2, 3, 2, 3, 1};

    for (int i = 0; i < WORDS + 3; i++) begin
      load_en = 1'b1;
      if (i < WORDS) begin
        load_addr = BASE + 32'(4 * i); load_data = $urandom;
      end else begin
        case (i - WORDS)
          0:       begin load_addr = BASE;       load_data = 32'h0000_0413; end
          1:       begin load_addr = BASE + 4;   load_data = 32'h0010_0093; end
          default: begin load_addr = BASE + 12;  load_data = 32'hAAAA_0003; end
        endcase
      end
      @(posedge clk); #1;
    end
    load_en = 1'b0;

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset rdata_valid[%0d]", k), 32'(o_vld[k]), 32'h0);
      chk($sformatf("reset rdata[%0d]", k), o_dat[k], 32'h0);
      chk($sformatf("reset rdata_err[%0d]", k), 32'(o_err[k]), 32'h0);
    end
    chk("req_ready in reset", 32'(o_rdy), 32'h0);
    rst = 1'b0; #1;
    chk("req_ready after reset", 32'(o_rdy), 32'h3);

    do_req(BASE, 1'b0, 0, 32'h0);           expect_req("word0", 2, 3, 32'h0000_0413, 1'b0);
    do_req(BASE + 4, 1'b0, 0, 32'h0);       expect_req("word1", 3, 3, 32'h0010_0093, 1'b0);
    do_req(32'h7FFF_FFFC, 1'b0, 0, 32'h0);  expect_req("below", 2, 3, 32'h0, 1'b1);
    do_req(BASE + 64, 1'b0, 0, 32'h0);      expect_req("above", 3, 3, 32'h0, 1'b1);
    do_req(BASE + 2, 1'b0, 0, 32'h0);       expect_req("unaligned", 1, 3, 32'h0000_0413, 1'b0);

    do_req(BASE + 4, 1'b1, 0, 32'h0);
    chk("hold lat_b", 32'(r_lat[1]), 32'd3);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("hold rdata_valid", 32'(o_vld), 32'h3);
      chk("hold rdata_a", o_dat[0], 32'h0010_0093);
      chk("hold rdata_b", o_dat[1], 32'h0010_0093);
      chk("hold req_ready", 32'(o_rdy), 32'h0);
    end
    rdata_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready after handshake", 32'(o_rdy), 32'h3);

    do_req(BASE + 12, 1'b0, 2, 32'hBBBB_0003);
    chk("rbw old data", r_dat[1], 32'hAAAA_0003);
    do_req(BASE + 12, 1'b0, 0, 32'h0);
    chk("rbw new data_a", r_dat[0], 32'hBBBB_0003);
    chk("rbw new data_b", r_dat[1], 32'hBBBB_0003);

    wait_idle();
    req_addr = BASE + 4; req_valid = 1'b1; rdata_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("req_ready during rst", 32'(o_rdy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("req_ready after abort", 32'(o_rdy), 32'h3);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (o_vld[1]) seen++;
    end
    chk("aborted response", 32'(seen), 32'h0);
    do_req(BASE, 1'b0, 0, 32'h0);           expect_req("post abort", 2, 3, 32'h0000_0413, 1'b0);

    collect(0);
    collect(1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("delay range %0d", i), 32'(seqs[0][i] >= 1 && seqs[0][i] <= 4), 32'h1);
      chk($sformatf("delay repeat %0d", i), 32'(seqs[1][i]), 32'(seqs[0][i]));
    end
    for (int i = 0; i < 5; i++) chk($sformatf("delay seq %0d", i), 32'(seqs[0][i]), 32'(exp5[i]));

    for (int c = 0; c < 3000; c++) begin
      req_valid   = ($urandom_range(0, 9) < 6);
      req_addr    = rnd_addr();
      rdata_ready = $urandom_range(0, 1) == 1;
      load_en     = ($urandom_range(0, 9) < 3);
      load_addr   = rnd_addr();
      load_data   = $urandom;
      rst         = ($urandom_range(0, 249) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; req_valid = 1'b0; load_en = 1'b0; rdata_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
